// File: rtl/reg_bank_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_bank_pkg : shared encodings and next-value helper            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package reg_bank_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    FS_CLR  = 2'd0,
    FS_LOAD = 2'd1,
    FS_DEC  = 2'd2,
    FS_INC  = 2'd3
  } fun_sel_e;

  typedef struct packed {
    logic             wrap;
    logic [MAX_W-1:0] value;
  } next_t;

  // Operands are zero-extended to MAX_W; max_val is the all-ones pattern of the real width.
  function automatic next_t next_value(input logic [MAX_W-1:0] cur,
                                       input logic [MAX_W-1:0] load,
                                       input logic [MAX_W-1:0] max_val,
                                       input fun_sel_e         fs,
                                       input logic             sat);
    next_t r;
    r.wrap  = 1'b0;
    r.value = cur;
    case (fs)
      FS_CLR:  r.value = '0;
      FS_LOAD: r.value = load;
      FS_DEC: begin
        if (cur == '0) begin
          r.wrap  = 1'b1;
          r.value = sat ? '0 : max_val;
        end else begin
          r.value = cur - 1'b1;
        end
      end
      FS_INC: begin
        if (cur == max_val) begin
          r.wrap  = 1'b1;
          r.value = sat ? max_val : '0;
        end else begin
          r.value = cur + 1'b1;
        end
      end
      default: r.value = cur;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_cell_p.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_cell_p : one register with shadow copy and sticky wrap flag  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_cell_p
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  fun_sel_e         fun_sel,
  input  logic [WIDTH-1:0] data,
  input  logic             snap,
  input  logic             restore,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             flag
);

  logic [WIDTH-1:0] shadow;
  logic [MAX_W-1:0] cur_ext;
  logic [MAX_W-1:0] load_ext;
  logic [MAX_W-1:0] max_ext;
  next_t            nxt;
  logic             flag_nxt;
  logic             unused_hi;

  always_comb begin
    cur_ext              = '0;
    cur_ext[WIDTH-1:0]   = q;
    load_ext             = '0;
    load_ext[WIDTH-1:0]  = data;
    max_ext              = '0;
    max_ext[WIDTH-1:0]   = '1;
    nxt                  = next_value(cur_ext, load_ext, max_ext, fun_sel, SAT != 0);
  end

  // Bits above WIDTH are always zero because every operand is masked to WIDTH.
  assign unused_hi = ^nxt.value;

  // A wrap event in the same cycle overrides either form of clearing.
  always_comb begin
    flag_nxt = flag;
    if (clr_flags)                  flag_nxt = 1'b0;
    if (en && fun_sel == FS_CLR)    flag_nxt = 1'b0;
    if (en && nxt.wrap)             flag_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      shadow <= '0;
      flag   <= 1'b0;
    end else if (restore) begin
      q <= shadow;
      if (snap) shadow <= q;
    end else begin
      if (en)   q      <= nxt.value[WIDTH-1:0];
      if (snap) shadow <= q;
      flag <= flag_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_p.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_bank_p : parametrised register bank, shadow, wrap/sat, bypass|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_bank_p
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int SEL_W  = $clog2(DEPTH),
  parameter int SAT    = 0,
  parameter int BYPASS = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [DEPTH-1:0] RSel,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  input  logic             Snap,
  input  logic             Restore,
  input  logic             ClrFlags,
  input  logic [SEL_W-1:0] O1Sel,
  input  logic [SEL_W-1:0] O2Sel,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [DEPTH-1:0] WrapFlag
);

  logic [WIDTH-1:0] regs [DEPTH];
  fun_sel_e         fs;
  logic             load_now;

  assign fs       = fun_sel_e'(FunSel);
  assign load_now = (BYPASS != 0) && (fs == FS_LOAD) && !Restore;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    reg_cell_p #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_cell (
      .clk       (CLK),
      .rst_n     (RST_N),
      .en        (!RSel[k]),
      .fun_sel   (fs),
      .data      (I),
      .snap      (Snap),
      .restore   (Restore),
      .clr_flags (ClrFlags),
      .q         (regs[k]),
      .flag      (WrapFlag[k])
    );
  end

  // Selects beyond DEPTH read zero; a load in flight is forwarded when bypass is on.
  always_comb begin
    O1 = '0;
    if (int'(O1Sel) < DEPTH) begin
      O1 = regs[O1Sel];
      if (load_now && !RSel[O1Sel]) O1 = I;
    end
  end

  always_comb begin
    O2 = '0;
    if (int'(O2Sel) < DEPTH) begin
      O2 = regs[O2Sel];
      if (load_now && !RSel[O2Sel]) O2 = I;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_p.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_bank_p : directed bench for reg_bank_p variants           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_reg_bank_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rsel;
  logic [1:0] fs;
  logic [7:0] din;
  logic       snap, restore, clrf;
  logic [2:0] o1sel, o2sel;

  logic [7:0] a_o1, a_o2, a_wf;
  logic [7:0] s_o1, s_o2, s_wf;
  logic [7:0] d_o1, d_o2;
  logic [5:0] d_wf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Default: wrap arithmetic with bypass
  reg_bank_p #(.WIDTH(8), .DEPTH(8), .SAT(0), .BYPASS(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .RSel(rsel), .FunSel(fs), .I(din),
    .Snap(snap), .Restore(restore), .ClrFlags(clrf),
    .O1Sel(o1sel), .O2Sel(o2sel), .O1(a_o1), .O2(a_o2), .WrapFlag(a_wf));

  // Saturating arithmetic, no bypass
  reg_bank_p #(.WIDTH(8), .DEPTH(8), .SAT(1), .BYPASS(0)) dut_s (
    .CLK(clk), .RST_N(rst_n), .RSel(rsel), .FunSel(fs), .I(din),
    .Snap(snap), .Restore(restore), .ClrFlags(clrf),
    .O1Sel(o1sel), .O2Sel(o2sel), .O1(s_o1), .O2(s_o2), .WrapFlag(s_wf));

  // Non-power-of-two depth for out-of-range selects
  reg_bank_p #(.WIDTH(8), .DEPTH(6), .SAT(0), .BYPASS(1)) dut_d (
    .CLK(clk), .RST_N(rst_n), .RSel(rsel[5:0]), .FunSel(fs), .I(din),
    .Snap(snap), .Restore(restore), .ClrFlags(clrf),
    .O1Sel(o1sel), .O2Sel(o2sel), .O1(d_o1), .O2(d_o2), .WrapFlag(d_wf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rsel    = 8'hFF;
    fs      = 2'd0;
    din     = 8'h00;
    snap    = 1'b0;
    restore = 1'b0;
    clrf    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    rsel = 8'h00; fs = 2'd1; din = 8'hFF;
    tick();
    fs = 2'd3;
    tick();
    idle();
    o1sel = 3'd0; o2sel = 3'd7;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_o1 !== 8'h00) begin n_bad++; $display("FAIL reset_o1 got=%h exp=%h", a_o1, 8'h00); end
    n_cmp++; if (a_o2 !== 8'h00) begin n_bad++; $display("FAIL reset_o2 got=%h exp=%h", a_o2, 8'h00); end
    n_cmp++; if (a_wf !== 8'h00) begin n_bad++; $display("FAIL reset_wf got=%h exp=%h", a_wf, 8'h00); end
    n_cmp++; if (s_o1 !== 8'h00) begin n_bad++; $display("FAIL reset_sat_o1 got=%h exp=%h", s_o1, 8'h00); end
    n_cmp++; if (s_wf !== 8'h00) begin n_bad++; $display("FAIL reset_sat_wf got=%h exp=%h", s_wf, 8'h00); end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_bypass();
    rsel = 8'hFE; fs = 2'd1; din = 8'hA5; o1sel = 3'd0;
    #1;
    n_cmp++; if (a_o1 !== 8'hA5) begin n_bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", a_o1, 8'hA5); end
    n_cmp++; if (s_o1 !== 8'h00) begin n_bad++; $display("FAIL nobypass_same_cycle got=%h exp=%h", s_o1, 8'h00); end
    tick();
    idle();
    #1;
    n_cmp++; if (a_o1 !== 8'hA5) begin n_bad++; $display("FAIL load_after_edge got=%h exp=%h", a_o1, 8'hA5); end
    n_cmp++; if (s_o1 !== 8'hA5) begin n_bad++; $display("FAIL nobypass_after_edge got=%h exp=%h", s_o1, 8'hA5); end
  endtask

  task automatic test_wrap_sat();
    rsel = 8'hF7; fs = 2'd1; din = 8'hFF;
    tick();
    fs = 2'd3;
    tick();
    idle(); o1sel = 3'd3;
    #1;
    n_cmp++; if (a_o1 !== 8'h00) begin n_bad++; $display("FAIL inc_wrap got=%h exp=%h", a_o1, 8'h00); end
    n_cmp++; if (a_wf !== 8'h08) begin n_bad++; $display("FAIL inc_wrap_flag got=%h exp=%h", a_wf, 8'h08); end
    n_cmp++; if (s_o1 !== 8'hFF) begin n_bad++; $display("FAIL inc_sat got=%h exp=%h", s_o1, 8'hFF); end
    n_cmp++; if (s_wf !== 8'h08) begin n_bad++; $display("FAIL inc_sat_flag got=%h exp=%h", s_wf, 8'h08); end
    // Clear together with increment: only the saturating bank sees a new event.
    clrf = 1'b1; rsel = 8'hF7; fs = 2'd3;
    tick();
    idle();
    #1;
    n_cmp++; if (a_wf !== 8'h00) begin n_bad++; $display("FAIL clr_no_event got=%h exp=%h", a_wf, 8'h00); end
    n_cmp++; if (s_wf !== 8'h08) begin n_bad++; $display("FAIL clr_event_wins got=%h exp=%h", s_wf, 8'h08); end
    n_cmp++; if (a_o1 !== 8'h01) begin n_bad++; $display("FAIL inc_after_wrap got=%h exp=%h", a_o1, 8'h01); end
    n_cmp++; if (s_o1 !== 8'hFF) begin n_bad++; $display("FAIL sat_hold got=%h exp=%h", s_o1, 8'hFF); end
    clrf = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++; if (s_wf !== 8'h00) begin n_bad++; $display("FAIL clrflags got=%h exp=%h", s_wf, 8'h00); end
  endtask

  task automatic test_dec_zero();
    rsel = 8'hDF; fs = 2'd2;
    tick();
    idle(); o1sel = 3'd5;
    #1;
    n_cmp++; if (a_o1 !== 8'hFF) begin n_bad++; $display("FAIL dec_wrap got=%h exp=%h", a_o1, 8'hFF); end
    n_cmp++; if (a_wf !== 8'h20) begin n_bad++; $display("FAIL dec_wrap_flag got=%h exp=%h", a_wf, 8'h20); end
    n_cmp++; if (s_o1 !== 8'h00) begin n_bad++; $display("FAIL dec_sat got=%h exp=%h", s_o1, 8'h00); end
    n_cmp++; if (s_wf !== 8'h20) begin n_bad++; $display("FAIL dec_sat_flag got=%h exp=%h", s_wf, 8'h20); end
    rsel = 8'hDF; fs = 2'd0;
    tick();
    idle();
    #1;
    n_cmp++; if (a_o1 !== 8'h00) begin n_bad++; $display("FAIL clear_reg got=%h exp=%h", a_o1, 8'h00); end
    n_cmp++; if (a_wf !== 8'h00) begin n_bad++; $display("FAIL clear_flag got=%h exp=%h", a_wf, 8'h00); end
    n_cmp++; if (s_wf !== 8'h00) begin n_bad++; $display("FAIL clear_sat_flag got=%h exp=%h", s_wf, 8'h00); end
  endtask

  task automatic test_snap_restore();
    rsel = 8'hFD; fs = 2'd1; din = 8'h12;
    tick();
    snap = 1'b1; fs = 2'd3;
    tick();
    idle(); o1sel = 3'd1; o2sel = 3'd0;
    #1;
    n_cmp++; if (a_o1 !== 8'h13) begin n_bad++; $display("FAIL snap_with_inc got=%h exp=%h", a_o1, 8'h13); end
    rsel = 8'hFD; fs = 2'd3;
    tick();
    tick();
    rsel = 8'hFE; fs = 2'd1; din = 8'h77;
    tick();
    idle();
    #1;
    n_cmp++; if (a_o1 !== 8'h15) begin n_bad++; $display("FAIL two_incs got=%h exp=%h", a_o1, 8'h15); end
    n_cmp++; if (a_o2 !== 8'h77) begin n_bad++; $display("FAIL reg0_changed got=%h exp=%h", a_o2, 8'h77); end
    // Restore overrides enables and FunSel, and suppresses bypass.
    restore = 1'b1; rsel = 8'h00; fs = 2'd1; din = 8'hEE;
    #1;
    n_cmp++; if (a_o1 !== 8'h15) begin n_bad++; $display("FAIL restore_no_bypass got=%h exp=%h", a_o1, 8'h15); end
    tick();
    idle();
    #1;
    n_cmp++; if (a_o1 !== 8'h12) begin n_bad++; $display("FAIL restore_reg1 got=%h exp=%h", a_o1, 8'h12); end
    n_cmp++; if (a_o2 !== 8'hA5) begin n_bad++; $display("FAIL restore_reg0 got=%h exp=%h", a_o2, 8'hA5); end
    n_cmp++; if (s_o1 !== 8'h12) begin n_bad++; $display("FAIL restore_sat_reg1 got=%h exp=%h", s_o1, 8'h12); end
    n_cmp++; if (s_o2 !== 8'hA5) begin n_bad++; $display("FAIL restore_sat_reg0 got=%h exp=%h", s_o2, 8'hA5); end
  endtask

  task automatic test_swap_oor();
    rsel = 8'hFB; fs = 2'd1; din = 8'h22;
    tick();
    idle(); snap = 1'b1;
    tick();
    idle(); rsel = 8'hFB; fs = 2'd1; din = 8'h11;
    tick();
    idle(); snap = 1'b1; restore = 1'b1;
    tick();
    idle(); o1sel = 3'd2;
    #1;
    n_cmp++; if (a_o1 !== 8'h22) begin n_bad++; $display("FAIL swap_reg got=%h exp=%h", a_o1, 8'h22); end
    restore = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++; if (a_o1 !== 8'h11) begin n_bad++; $display("FAIL swap_shadow got=%h exp=%h", a_o1, 8'h11); end
    rsel = 8'h00; fs = 2'd1; din = 8'h5A;
    tick();
    idle(); o1sel = 3'd7; o2sel = 3'd5;
    #1;
    n_cmp++; if (a_o1 !== 8'h5A) begin n_bad++; $display("FAIL sel7_depth8 got=%h exp=%h", a_o1, 8'h5A); end
    n_cmp++; if (d_o1 !== 8'h00) begin n_bad++; $display("FAIL sel7_depth6 got=%h exp=%h", d_o1, 8'h00); end
    n_cmp++; if (d_o2 !== 8'h5A) begin n_bad++; $display("FAIL sel5_depth6 got=%h exp=%h", d_o2, 8'h5A); end
    o1sel = 3'd6;
    #1;
    n_cmp++; if (d_o1 !== 8'h00) begin n_bad++; $display("FAIL sel6_depth6 got=%h exp=%h", d_o1, 8'h00); end
    // Bypass must not reach a select beyond DEPTH.
    rsel = 8'h00; fs = 2'd1; din = 8'h3C;
    #1;
    n_cmp++; if (d_o1 !== 8'h00) begin n_bad++; $display("FAIL oor_no_bypass got=%h exp=%h", d_o1, 8'h00); end
    n_cmp++; if (d_o2 !== 8'h3C) begin n_bad++; $display("FAIL bypass_depth6 got=%h exp=%h", d_o2, 8'h3C); end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    o1sel = 3'd0;
    o2sel = 3'd7;
    repeat (2) tick();
    test_reset();
    test_load_bypass();
    test_wrap_sat();
    test_dec_zero();
    test_snap_restore();
    test_swap_oor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_bank_p.md
Name: reg_bank_p

Overview:
- Parametrised successor to the fixed 4+4 register file: DEPTH registers of WIDTH bits, two combinational read ports, and a shared FunSel operation applied to every enabled register.
- Adds a per-register shadow bank with one-cycle snapshot, restore and swap.
- Adds selectable wrap or saturate for increment/decrement, sticky per-register wrap flags, and optional load bypass to the read ports.
- Sits in the datapath in place of the general-purpose/temporary register file, fed by the ALU/memory mux.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, number of registers (2..16).
- SEL_W, $clog2(DEPTH), width of the read-select ports.
- SAT, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec saturate at all-ones/zero.
- BYPASS, 1, 1 = a register being loaded this cycle is forwarded from I to any read port selecting it.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- RSel  in  DEPTH  per-register enable, active-low (bit k = 0 enables register k).
- FunSel  in  2  operation: 0 clear, 1 load I, 2 decrement, 3 increment.
- I  in  WIDTH  load data.
- Snap  in  1  copy all registers into the shadow bank.
- Restore  in  1  copy the shadow bank into all registers.
- ClrFlags  in  1  clear all sticky wrap flags.
- O1Sel  in  SEL_W  read select, port 1.
- O2Sel  in  SEL_W  read select, port 2.
- O1  out  WIDTH  read data, port 1.
- O2  out  WIDTH  read data, port 2.
- WrapFlag  out  DEPTH  sticky per-register wrap/saturation event flag.

Behaviour:
- Reset (RST_N = 0, asynchronous):
  - All registers, shadows and WrapFlag go to 0; O1/O2 read 0.
  - Reset dominates every other input.
  - Deassertion is taken synchronously; the first update occurs on the first posedge with RST_N = 1.
  - Reset mid-operation (during Snap/Restore/inc) discards that operation entirely.
- Operation per posedge, for each register k, in priority order:
  1. Restore=1 and Snap=0: reg[k] <= shadow[k] for all k, regardless of RSel/FunSel; WrapFlag unchanged.
  2. Restore=1 and Snap=1: swap, reg[k] <= shadow[k] and shadow[k] <= reg[k] (both use pre-edge values).
  3. Otherwise, if RSel[k] = 0, apply FunSel:
     - 0: reg <= 0 and WrapFlag[k] <= 0.
     - 1: reg <= I.
     - 2: reg <= reg-1.
     - 3: reg <= reg+1.
  4. Snap=1 with Restore=0: shadow[k] <= pre-edge reg[k], i.e. the value before this cycle's FunSel update. Snap and FunSel therefore coexist in the same cycle.
- Wrap and saturation:
  - Increment at all-ones: SAT=0 gives 0; SAT=1 holds all-ones.
  - Decrement at 0: SAT=0 gives all-ones; SAT=1 holds 0.
  - Either event sets WrapFlag[k] <= 1 (sticky).
- WrapFlag clearing:
  - ClrFlags=1 clears all flags.
  - A set event in the same cycle wins for that bit, so the flag reads 1 after the edge.
  - FunSel=0 on register k clears WrapFlag[k].
- Disabled registers (RSel[k]=1) hold their value. RSel all-ones with no Snap/Restore is a no-op.
- Reads:
  - O1 = reg[O1Sel] and O2 = reg[O2Sel], purely combinational, zero latency.
  - Both ports may select the same register.
  - A select value >= DEPTH reads 0.
  - BYPASS=1: if the selected register has RSel=0, FunSel=1 and Restore=0, the port outputs I combinationally. No bypass for inc/dec/clear.
  - BYPASS=0: reads always show the registered value; a write is visible on the next cycle.
- Arithmetic is unsigned, WIDTH bits. No carries are exported.

Decomposition:
- Shared package reg_bank_pkg:
  - FunSel encodings FS_CLR=2'd0, FS_LOAD=2'd1, FS_DEC=2'd2, FS_INC=2'd3.
  - A function returning next value plus wrap bit, given (value, FunSel, SAT).
- One natural sub-module, reg_cell_p: one register with its shadow, its flag and the priority logic, instantiated DEPTH times via generate.
- Read muxes and bypass stay in the top level.

Test Plan (all scenarios WIDTH=8, DEPTH=8):
- Reset then read: pulse RST_N low between edges, O1Sel=0, O2Sel=7 -> O1=O2=8'h00 and WrapFlag=0 immediately, without waiting for an edge.
- Load with bypass: RSel=8'b1111_1110, FunSel=1, I=8'hA5, O1Sel=0 -> O1=A5 in the same cycle (BYPASS=1), and reg0=A5 after the edge; with BYPASS=0, O1 stays 00 until after the edge.
- Wrap vs saturate: reg3=FF, then FunSel=3 with RSel[3]=0 -> SAT=0 gives 00 and WrapFlag[3]=1; SAT=1 gives FF and WrapFlag[3]=1. Then ClrFlags=1 -> WrapFlag=0.
- Decrement at zero: reg5=00, FunSel=2 -> SAT=0 gives FF and WrapFlag[5]=1. A following FunSel=0 on reg5 -> 00 and WrapFlag[5]=0.
- Snap then restore:
  - reg1=12; Snap=1 together with FunSel=3 on reg1 -> reg1=13 and shadow1=12.
  - Two further increments -> reg1=15.
  - Restore=1 -> reg1=12; other registers revert to their snapshot values.
- Swap and out-of-range select: reg2=11, shadow2=22; Snap=Restore=1 -> reg2=22, shadow2=11. With DEPTH=6, O1Sel=7 -> O1=00.
